// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// Module   : bus_pkg
// Shared 16-bit peripheral bus constants and bus-master state encoding.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] RAM_BASE = 16'h0000;
  localparam logic [ADDR_W-1:0] SP_BASE  = 16'hEFF0;
  localparam logic [ADDR_W-1:0] TB_BASE  = 16'hF000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } dma_state_e;

endpackage

`default_nettype wire

// File: rtl/vblank_dma_edge_detect.sv
// ----------------------------------------------------------------------------
// Module   : edge_detect
// Rising/falling strobes of a level, derived from its one-clk-delayed copy.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic r_sig_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= sig;
    end
  end

  // Strobes are valid in the same cycle the new level is seen, so the
  // consumer acts on the first edge after the transition.
  assign rise = sig & ~r_sig_q;
  assign fall = ~sig & r_sig_q;

endmodule

`default_nettype wire

// File: rtl/vblank_dma.sv
// ----------------------------------------------------------------------------
// Module   : vblank_dma
// vsync-triggered bus-master block copy from work RAM to any bus address.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vblank_dma
  import bus_pkg::*;
#(
  parameter int LEN_W   = 11,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              enable,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              bus_gnt,
  input  logic [DATA_W-1:0] din,
  output logic              bus_req,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              rw,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int CNT_W = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;

  dma_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_src, w_src_nxt;
  logic [ADDR_W-1:0] r_dst, w_dst_nxt;
  logic [LEN_W-1:0]  r_remaining, w_remaining_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_abort, w_abort_nxt;

  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_dout_nxt;
  logic              w_rw_nxt;
  logic              w_req_nxt;
  logic              w_done_nxt;
  logic              w_overrun_nxt;

  logic              w_rise;
  logic              w_fall;
  logic [ADDR_W-1:0] w_src_inc;
  logic [ADDR_W-1:0] w_dst_inc;
  logic [LEN_W-1:0]  w_rem_dec;

  edge_detect u_vsync_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (vsync),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  assign w_src_inc = r_src + ADDR_W'(1);
  assign w_dst_inc = r_dst + ADDR_W'(1);
  assign w_rem_dec = r_remaining - LEN_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_remaining <= '0;
      r_cnt       <= '0;
      r_abort     <= 1'b0;
      addr        <= '0;
      dout        <= '0;
      rw          <= 1'b0;
      bus_req     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_src       <= w_src_nxt;
      r_dst       <= w_dst_nxt;
      r_remaining <= w_remaining_nxt;
      r_cnt       <= w_cnt_nxt;
      r_abort     <= w_abort_nxt;
      addr        <= w_addr_nxt;
      dout        <= w_dout_nxt;
      rw          <= w_rw_nxt;
      bus_req     <= w_req_nxt;
      busy        <= (w_state_nxt != IDLE);
      done        <= w_done_nxt;
      overrun     <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_src_nxt       = r_src;
    w_dst_nxt       = r_dst;
    w_remaining_nxt = r_remaining;
    w_cnt_nxt       = r_cnt;
    w_abort_nxt     = r_abort;
    w_addr_nxt      = addr;
    w_dout_nxt      = dout;
    w_rw_nxt        = rw;
    w_req_nxt       = bus_req;
    w_done_nxt      = 1'b0;
    w_overrun_nxt   = overrun;

    case (r_state)
      IDLE: begin
        if (w_rise && enable && (cfg_len != '0)) begin
          w_src_nxt       = cfg_src;
          w_dst_nxt       = cfg_dst;
          w_remaining_nxt = cfg_len;
          w_overrun_nxt   = 1'b0;
          w_abort_nxt     = 1'b0;
          w_req_nxt       = 1'b1;
          w_state_nxt     = REQ;
        end
      end

      REQ: begin
        if (bus_gnt) begin
          w_addr_nxt  = r_src;
          w_rw_nxt    = 1'b0;
          w_cnt_nxt   = CNT_W'(RD_WAIT);
          w_state_nxt = RD;
        end
      end

      RD: begin
        // Losing the bus mid-read restarts this byte from r_src on re-grant.
        if (!bus_gnt) begin
          w_rw_nxt    = 1'b0;
          w_state_nxt = REQ;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_dout_nxt  = din;
          w_addr_nxt  = r_dst;
          w_rw_nxt    = 1'b1;
          w_state_nxt = WR;
        end
      end

      WR: begin
        // The strobe has already been presented, so the byte always retires.
        w_rw_nxt        = 1'b0;
        w_src_nxt       = w_src_inc;
        w_dst_nxt       = w_dst_inc;
        w_remaining_nxt = w_rem_dec;
        if ((w_rem_dec == '0) || r_abort) begin
          w_req_nxt   = 1'b0;
          w_addr_nxt  = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else if (!bus_gnt) begin
          w_state_nxt = REQ;
        end else begin
          w_addr_nxt  = w_src_inc;
          w_cnt_nxt   = CNT_W'(RD_WAIT);
          w_state_nxt = RD;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // A vblank that ends early or a second vsync while copying is an error.
    if (r_state != IDLE) begin
      if (w_fall) begin
        w_abort_nxt   = 1'b1;
        w_overrun_nxt = 1'b1;
      end
      if (w_rise) begin
        w_overrun_nxt = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vblank_dma.sv
// ----------------------------------------------------------------------------
// Module   : tb_vblank_dma
// Directed bench for vblank_dma with a behavioural bus memory and write log.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vblank_dma;

  logic        clk;
  logic        reset;
  logic        vsync;
  logic        enable;
  logic [15:0] cfg_src;
  logic [15:0] cfg_dst;
  logic [10:0] cfg_len;
  logic        bus_gnt;
  logic [7:0]  din;
  logic        bus_req;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        rw;
  logic        busy;
  logic        done;
  logic        overrun;

  logic [7:0]  mem [0:65535];
  logic [15:0] wr_addr [0:255];
  logic [7:0]  wr_data [0:255];
  int          n_wr;
  int          n_done;
  int          n_req;
  int          n_rw_nogrant;

  int n_checks;
  int n_errors;

  vblank_dma #(
    .LEN_W   (11),
    .RD_WAIT (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .vsync   (vsync),
    .enable  (enable),
    .cfg_src (cfg_src),
    .cfg_dst (cfg_dst),
    .cfg_len (cfg_len),
    .bus_gnt (bus_gnt),
    .din     (din),
    .bus_req (bus_req),
    .addr    (addr),
    .dout    (dout),
    .rw      (rw),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign din = mem[addr];

  initial begin
    n_wr         = 0;
    n_done       = 0;
    n_req        = 0;
    n_rw_nogrant = 0;
  end

  // Bus observer: every rw=1 cycle is one write strobe.
  always @(negedge clk) begin
    if (rw) begin
      if (n_wr < 256) begin
        wr_addr[n_wr[7:0]] <= addr;
        wr_data[n_wr[7:0]] <= dout;
      end
      n_wr <= n_wr + 1;
    end
    if (rw && !bus_gnt) n_rw_nogrant <= n_rw_nogrant + 1;
    if (done)           n_done <= n_done + 1;
    if (bus_req)        n_req <= n_req + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic trig(input logic [15:0] s, input logic [15:0] d,
                      input logic [10:0] l, input logic en);
    cfg_src = s;
    cfg_dst = d;
    cfg_len = l;
    enable  = en;
    vsync   = 1'b1;
    tick();
  endtask

  task automatic vs_low();
    vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int k;
    k = 0;
    while ((done !== 1'b1) && (k < max_cycles)) begin
      tick();
      k++;
    end
    check(tag, done, 1);
  endtask

  task automatic check_basic_writes(input string tag, input int b);
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    check({tag, "_nwr"}, n_wr - b, 4);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_wa"}, wr_addr[b+i], 16'hF000 + i);
      check({tag, "_wd"}, wr_data[b+i], exp_d[i]);
    end
  endtask

  initial begin
    int b, bd, br, bg;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h11;
    mem[16'h0101] = 8'h22;
    mem[16'h0102] = 8'h33;
    mem[16'h0103] = 8'h44;
    for (int i = 0; i < 16; i++) mem[16'h0200 + i] = 8'h40 + 8'(i);
    mem[16'hFFFE] = 8'hA1;
    mem[16'hFFFF] = 8'hA2;
    mem[16'h0000] = 8'hA3;

    reset   = 1'b1;
    vsync   = 1'b0;
    enable  = 1'b0;
    cfg_src = '0;
    cfg_dst = '0;
    cfg_len = '0;
    bus_gnt = 1'b1;
    tick();
    tick();
    check("rst_addr", addr, 0);
    check("rst_dout", dout, 0);
    check("rst_rw", rw, 0);
    check("rst_req", bus_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    tick();

    // Basic copy with exact cycle timing.
    b = n_wr; bd = n_done;
    trig(16'h0100, 16'hF000, 11'd4, 1'b1);
    check("bc_req", bus_req, 1);
    check("bc_busy", busy, 1);
    tick();
    check("bc_e0_addr", addr, 16'h0100);
    check("bc_e0_rw", rw, 0);
    tick();
    tick();
    check("bc_e2_rw", rw, 1);
    check("bc_e2_addr", addr, 16'hF000);
    check("bc_e2_dout", dout, 8'h11);
    repeat (10) tick();
    check("bc_e12_done", done, 1);
    check("bc_e12_req", bus_req, 0);
    check("bc_e12_addr", addr, 0);
    tick();
    check("bc_done_low", done, 0);
    check("bc_busy_low", busy, 0);
    check_basic_writes("bc", b);
    check("bc_ndone", n_done - bd, 1);
    vs_low();
    check("bc_ovr", overrun, 0);

    // Grant drop during byte 2 read.
    b = n_wr; bd = n_done; bg = n_rw_nogrant;
    trig(16'h0100, 16'hF000, 11'd4, 1'b1);
    repeat (4) tick();
    check("gd_e3_addr", addr, 16'h0101);
    bus_gnt = 1'b0;
    tick();
    check("gd_rw_low", rw, 0);
    check("gd_req_hold", bus_req, 1);
    tick();
    tick();
    bus_gnt = 1'b1;
    tick();
    check("gd_reread_addr", addr, 16'h0101);
    check("gd_reread_rw", rw, 0);
    wait_done("gd_done", 40);
    tick();
    check_basic_writes("gd", b);
    check("gd_rw_nogrant", n_rw_nogrant - bg, 0);
    check("gd_ndone", n_done - bd, 1);
    vs_low();

    // Abort: vsync falls 30 cycles after rising; byte 9 is in flight.
    b = n_wr;
    trig(16'h0200, 16'hF100, 11'd1000, 1'b1);
    repeat (29) tick();
    vsync = 1'b0;
    tick();
    check("ab_ovr", overrun, 1);
    check("ab_rw", rw, 1);
    check("ab_addr", addr, 16'hF109);
    tick();
    check("ab_done", done, 1);
    check("ab_req", bus_req, 0);
    repeat (5) tick();
    check("ab_nwr", n_wr - b, 10);
    check("ab_last_wd", wr_data[b+9], 8'h49);
    check("ab_busy", busy, 0);
    check("ab_ovr_sticky", overrun, 1);

    // Gating: zero length, then disabled.
    b = n_wr; br = n_req;
    trig(16'h0100, 16'hF000, 11'd0, 1'b1);
    repeat (10) tick();
    vs_low();
    trig(16'h0100, 16'hF000, 11'd4, 1'b0);
    repeat (10) tick();
    check("gt_nreq", n_req - br, 0);
    check("gt_nwr", n_wr - b, 0);
    check("gt_busy", busy, 0);
    check("gt_ovr_kept", overrun, 1);
    vs_low();

    // Address wrap; this accepted trigger also clears overrun.
    b = n_wr;
    trig(16'hFFFE, 16'hEFF0, 11'd3, 1'b1);
    check("wr_ovr_clr", overrun, 0);
    tick();
    check("wr_e0_addr", addr, 16'hFFFE);
    wait_done("wr_done", 20);
    tick();
    check("wr_nwr", n_wr - b, 3);
    check("wr_wa0", wr_addr[b], 16'hEFF0);
    check("wr_wd0", wr_data[b], 8'hA1);
    check("wr_wa1", wr_addr[b+1], 16'hEFF1);
    check("wr_wd1", wr_data[b+1], 8'hA2);
    check("wr_wa2", wr_addr[b+2], 16'hEFF2);
    check("wr_wd2", wr_data[b+2], 8'hA3);
    vs_low();

    // Async reset while the first write strobe is active.
    trig(16'h0100, 16'hF000, 11'd4, 1'b1);
    repeat (3) tick();
    check("ar_rw_pre", rw, 1);
    #1;
    reset = 1'b1;
    vsync = 1'b0;
    #1;
    check("ar_addr", addr, 0);
    check("ar_dout", dout, 0);
    check("ar_rw", rw, 0);
    check("ar_req", bus_req, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_ovr", overrun, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    b = n_wr;
    trig(16'h0100, 16'hF000, 11'd4, 1'b1);
    wait_done("ar2_done", 30);
    tick();
    check_basic_writes("ar2", b);
    check("ar2_busy", busy, 0);
    vs_low();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
